// File: rtl/pic_pkg.sv
// Shared types for the interrupt in-service / acknowledge logic.
package pic_pkg;

  typedef logic [2:0] level_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK1,
    ST_GAP,
    ST_ACK2
  } ack_state_t;

  localparam level_t SPURIOUS_LEVEL = 3'd7;

  function automatic logic [7:0] level_onehot(input level_t lvl);
    return 8'b1 << lvl;
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Rotating-priority resolver: picks the highest-priority request that outranks
// every in-service level. Purely combinational.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] request,
  input  logic [7:0] in_service,
  input  level_t     lowest_priority,
  output logic       valid,
  output level_t     level
);

  // Index 0 of the rotated vectors is the highest-priority level.
  logic [7:0] rotated_req;
  logic [7:0] rotated_isr;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rotate
      assign rotated_req[gi] = request[lowest_priority + 3'(gi + 1)];
      assign rotated_isr[gi] = in_service[lowest_priority + 3'(gi + 1)];
    end
  endgenerate

  logic   req_found;
  logic   isr_found;
  level_t req_rank;
  level_t isr_rank;

  always_comb begin
    req_found = 1'b0;
    isr_found = 1'b0;
    req_rank  = 3'd0;
    isr_rank  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rotated_req[i]) begin
        req_found = 1'b1;
        req_rank  = 3'(i);
      end
      if (rotated_isr[i]) begin
        isr_found = 1'b1;
        isr_rank  = 3'(i);
      end
    end
  end

  assign valid = req_found && (!isr_found || (req_rank < isr_rank));
  assign level = lowest_priority + 3'd1 + req_rank;

endmodule

// File: rtl/in_service_control.sv
// In-service register, two-pulse INTA acknowledge sequencer and EOI handling
// for an 8-level interrupt controller.
module in_service_control
  import pic_pkg::*;
#(
  parameter level_t LOWEST_PRIORITY_RESET = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] interrupt_req_register,
  input  logic [7:0] interrupt_mask,
  input  logic       inta_n,
  input  logic       aeoi_mode,
  input  logic       rotate_on_eoi,
  input  logic       eoi_nonspecific,
  input  logic       eoi_specific,
  input  level_t     eoi_level,
  input  logic [4:0] vector_base,
  output logic       interrupt_out,
  output logic [7:0] clear_interrupt_req,
  output logic [7:0] in_service_register,
  output logic [7:0] vector_out,
  output logic       vector_enable
);

  ack_state_t state_reg;
  logic       inta_prev_reg;
  level_t     lowest_priority_reg;
  level_t     latched_level_reg;
  logic       spurious_reg;
  logic [7:0] isr_reg;
  logic [7:0] clear_req_reg;
  logic       int_reg;
  logic [7:0] vector_reg;
  logic       vector_en_reg;

  logic       cand_valid;
  level_t     cand_level;
  logic       top_valid;
  level_t     top_level;

  priority_resolver u_candidate (
    .request         (interrupt_req_register & ~interrupt_mask),
    .in_service      (isr_reg),
    .lowest_priority (lowest_priority_reg),
    .valid           (cand_valid),
    .level           (cand_level)
  );

  // Highest-priority in-service level, target of a non-specific EOI.
  priority_resolver u_isr_top (
    .request         (isr_reg),
    .in_service      (8'h00),
    .lowest_priority (lowest_priority_reg),
    .valid           (top_valid),
    .level           (top_level)
  );

  logic       inta_fall;
  logic       inta_rise;
  logic       ack_grant;
  logic       aeoi_clear;
  logic       rotate_now;
  logic [7:0] isr_set;
  logic [7:0] isr_clear;
  logic [7:0] isr_next;

  assign inta_fall  = inta_prev_reg & ~inta_n;
  assign inta_rise  = ~inta_prev_reg & inta_n;
  assign ack_grant  = (state_reg == ST_IDLE) && inta_fall && cand_valid;
  assign aeoi_clear = (state_reg == ST_ACK2) && inta_rise && aeoi_mode && !spurious_reg;
  assign rotate_now = !eoi_specific && eoi_nonspecific && top_valid && rotate_on_eoi;

  always_comb begin
    isr_clear = 8'h00;
    if (eoi_specific)
      isr_clear = level_onehot(eoi_level);
    else if (eoi_nonspecific && top_valid)
      isr_clear = level_onehot(top_level);
    if (aeoi_clear)
      isr_clear = isr_clear | level_onehot(latched_level_reg);
  end

  assign isr_set  = ack_grant ? level_onehot(cand_level) : 8'h00;
  // Clear first, then set, so a new grant survives an EOI on the same bit.
  assign isr_next = (isr_reg & ~isr_clear) | isr_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg           <= ST_IDLE;
      inta_prev_reg       <= 1'b1;
      lowest_priority_reg <= LOWEST_PRIORITY_RESET;
      latched_level_reg   <= SPURIOUS_LEVEL;
      spurious_reg        <= 1'b0;
      isr_reg             <= 8'h00;
      clear_req_reg       <= 8'h00;
      int_reg             <= 1'b0;
      vector_reg          <= 8'h00;
      vector_en_reg       <= 1'b0;
    end else begin
      inta_prev_reg <= inta_n;
      isr_reg       <= isr_next;
      clear_req_reg <= isr_set;
      if (rotate_now)
        lowest_priority_reg <= top_level;

      case (state_reg)
        ST_IDLE: begin
          vector_reg    <= 8'h00;
          vector_en_reg <= 1'b0;
          if (inta_fall) begin
            state_reg         <= ST_ACK1;
            int_reg           <= 1'b0;
            latched_level_reg <= cand_valid ? cand_level : SPURIOUS_LEVEL;
            spurious_reg      <= !cand_valid;
          end else begin
            int_reg <= cand_valid;
          end
        end
        ST_ACK1: begin
          int_reg <= 1'b0;
          if (inta_rise)
            state_reg <= ST_GAP;
        end
        ST_GAP: begin
          int_reg <= 1'b0;
          if (inta_fall) begin
            state_reg     <= ST_ACK2;
            vector_en_reg <= 1'b1;
            vector_reg    <= {vector_base, latched_level_reg};
          end
        end
        ST_ACK2: begin
          int_reg <= 1'b0;
          if (inta_rise) begin
            state_reg     <= ST_IDLE;
            vector_en_reg <= 1'b0;
            vector_reg    <= 8'h00;
          end else begin
            vector_reg <= {vector_base, latched_level_reg};
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign interrupt_out       = int_reg;
  assign clear_interrupt_req = clear_req_reg;
  assign in_service_register = isr_reg;
  assign vector_out          = vector_reg;
  assign vector_enable       = vector_en_reg;

endmodule

// File: tb/tb_in_service_control.sv
// Directed bench for in_service_control: acknowledge sequence, nesting,
// spurious, AEOI, rotation and reset abort.
module tb_in_service_control;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr;
  logic [7:0] mask;
  logic       inta_n;
  logic       aeoi_mode;
  logic       rotate_on_eoi;
  logic       eoi_nonspecific;
  logic       eoi_specific;
  level_t     eoi_level;
  logic [4:0] vector_base;
  logic       interrupt_out;
  logic [7:0] clear_interrupt_req;
  logic [7:0] in_service_register;
  logic [7:0] vector_out;
  logic       vector_enable;

  int n_pass  = 0;
  int n_total = 0;

  in_service_control #(.LOWEST_PRIORITY_RESET(3'd7)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .interrupt_req_register (irr),
    .interrupt_mask         (mask),
    .inta_n                 (inta_n),
    .aeoi_mode              (aeoi_mode),
    .rotate_on_eoi          (rotate_on_eoi),
    .eoi_nonspecific        (eoi_nonspecific),
    .eoi_specific           (eoi_specific),
    .eoi_level              (eoi_level),
    .vector_base            (vector_base),
    .interrupt_out          (interrupt_out),
    .clear_interrupt_req    (clear_interrupt_req),
    .in_service_register    (in_service_register),
    .vector_out             (vector_out),
    .vector_enable          (vector_enable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two full INTA pulses; the upstream IRR bit is dropped after the first.
  task automatic do_ack(output logic [7:0] vec, output logic ven);
    inta_n = 1'b0; tick();
    irr    = 8'h00;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    vec = vector_out;
    ven = vector_enable;
    inta_n = 1'b1; tick();
    tick();
    $display("ack: vector=%02h enable=%0b isr=%02h", vec, ven, in_service_register);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_total++;
    if ({interrupt_out, clear_interrupt_req, in_service_register, vector_out, vector_enable} !== 26'h0)
      $display("FAIL reset_outputs: got int=%0b clr=%02h isr=%02h vec=%02h ven=%0b, want all 0",
               interrupt_out, clear_interrupt_req, in_service_register, vector_out, vector_enable);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_ack();
    irr = 8'h24; tick();
    n_total++;
    if (interrupt_out !== 1'b1) $display("FAIL basic_int: got %0b want 1", interrupt_out);
    else n_pass++;
    inta_n = 1'b0; tick();
    n_total++;
    if (clear_interrupt_req !== 8'h04) $display("FAIL basic_clear: got %02h want 04", clear_interrupt_req);
    else n_pass++;
    n_total++;
    if (in_service_register !== 8'h04) $display("FAIL basic_isr: got %02h want 04", in_service_register);
    else n_pass++;
    n_total++;
    if (interrupt_out !== 1'b0) $display("FAIL basic_int_drop: got %0b want 0", interrupt_out);
    else n_pass++;
    irr = 8'h20; tick();
    n_total++;
    if (clear_interrupt_req !== 8'h00) $display("FAIL basic_clear_once: got %02h want 00", clear_interrupt_req);
    else n_pass++;
    inta_n = 1'b1; tick();
    n_total++;
    if (vector_enable !== 1'b0) $display("FAIL basic_gap_ven: got %0b want 0", vector_enable);
    else n_pass++;
    irr = 8'h01;  // IR0 arriving mid-sequence must not alter the latched level
    inta_n = 1'b0; tick();
    n_total++;
    if (vector_enable !== 1'b1 || vector_out !== 8'hAA)
      $display("FAIL basic_vector: got ven=%0b vec=%02h want ven=1 vec=aa", vector_enable, vector_out);
    else n_pass++;
    $display("ack: vector=%02h enable=%0b isr=%02h", vector_out, vector_enable, in_service_register);
    irr = 8'h20;
    inta_n = 1'b1; tick();
    n_total++;
    if (vector_enable !== 1'b0 || vector_out !== 8'h00)
      $display("FAIL basic_vector_off: got ven=%0b vec=%02h want 0/00", vector_enable, vector_out);
    else n_pass++;
    tick();
    n_total++;
    if (interrupt_out !== 1'b0) $display("FAIL basic_lower_blocked: got %0b want 0", interrupt_out);
    else n_pass++;
  endtask

  task automatic test_nesting();
    irr = 8'h08; tick(); tick();
    n_total++;
    if (interrupt_out !== 1'b0) $display("FAIL nest_lower: got %0b want 0", interrupt_out);
    else n_pass++;
    irr = 8'h01; tick();
    n_total++;
    if (interrupt_out !== 1'b1) $display("FAIL nest_higher: got %0b want 1", interrupt_out);
    else n_pass++;
    irr = 8'h00; tick();
    eoi_specific = 1'b1; eoi_level = 3'd2; tick();
    eoi_specific = 1'b0;
    n_total++;
    if (in_service_register !== 8'h00) $display("FAIL nest_specific_eoi: got %02h want 00", in_service_register);
    else n_pass++;
  endtask

  task automatic test_spurious();
    irr = 8'h08; tick();
    n_total++;
    if (interrupt_out !== 1'b1) $display("FAIL spur_int: got %0b want 1", interrupt_out);
    else n_pass++;
    irr = 8'h00; tick();
    n_total++;
    if (interrupt_out !== 1'b0) $display("FAIL spur_int_withdrawn: got %0b want 0", interrupt_out);
    else n_pass++;
    inta_n = 1'b0; tick();
    n_total++;
    if (clear_interrupt_req !== 8'h00 || in_service_register !== 8'h00)
      $display("FAIL spur_no_grant: got clr=%02h isr=%02h want 00/00", clear_interrupt_req, in_service_register);
    else n_pass++;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    n_total++;
    if (vector_out !== 8'hAF || vector_enable !== 1'b1)
      $display("FAIL spur_vector: got vec=%02h ven=%0b want af/1", vector_out, vector_enable);
    else n_pass++;
    $display("ack: vector=%02h enable=%0b isr=%02h", vector_out, vector_enable, in_service_register);
    inta_n = 1'b1; tick();
    n_total++;
    if (in_service_register !== 8'h00) $display("FAIL spur_isr: got %02h want 00", in_service_register);
    else n_pass++;
  endtask

  task automatic test_aeoi();
    aeoi_mode = 1'b1;
    irr = 8'h20; tick();
    inta_n = 1'b0; tick();
    irr = 8'h00;
    n_total++;
    if (in_service_register !== 8'h20) $display("FAIL aeoi_set: got %02h want 20", in_service_register);
    else n_pass++;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    n_total++;
    if (vector_out !== 8'hAD || in_service_register !== 8'h20)
      $display("FAIL aeoi_ack2: got vec=%02h isr=%02h want ad/20", vector_out, in_service_register);
    else n_pass++;
    $display("ack: vector=%02h enable=%0b isr=%02h", vector_out, vector_enable, in_service_register);
    inta_n = 1'b1; tick();
    n_total++;
    if (in_service_register !== 8'h00) $display("FAIL aeoi_clear: got %02h want 00", in_service_register);
    else n_pass++;
    aeoi_mode = 1'b0;
    tick();
  endtask

  task automatic test_rotate();
    logic [7:0] vec;
    logic       ven;
    irr = 8'h04; tick();
    do_ack(vec, ven);
    irr = 8'h02; tick();
    n_total++;
    if (interrupt_out !== 1'b1) $display("FAIL rot_nest_int: got %0b want 1", interrupt_out);
    else n_pass++;
    do_ack(vec, ven);
    n_total++;
    if (in_service_register !== 8'h06 || vec !== 8'hA9)
      $display("FAIL rot_setup: got isr=%02h vec=%02h want 06/a9", in_service_register, vec);
    else n_pass++;
    rotate_on_eoi = 1'b1; eoi_nonspecific = 1'b1; tick();
    rotate_on_eoi = 1'b0; eoi_nonspecific = 1'b0;
    n_total++;
    if (in_service_register !== 8'h04) $display("FAIL rot_nonspec_eoi: got %02h want 04", in_service_register);
    else n_pass++;
    // Specific EOI together with a non-specific one: only IR2 clears, no rotation.
    eoi_specific = 1'b1; eoi_nonspecific = 1'b1; rotate_on_eoi = 1'b1; eoi_level = 3'd2; tick();
    eoi_specific = 1'b0; eoi_nonspecific = 1'b0; rotate_on_eoi = 1'b0;
    n_total++;
    if (in_service_register !== 8'h00) $display("FAIL rot_spec_wins: got %02h want 00", in_service_register);
    else n_pass++;
    irr = 8'h03; tick();
    do_ack(vec, ven);
    n_total++;
    if (vec !== 8'hA8 || ven !== 1'b1 || in_service_register !== 8'h01)
      $display("FAIL rot_ir0_first: got vec=%02h ven=%0b isr=%02h want a8/1/01", vec, ven, in_service_register);
    else n_pass++;
    irr = 8'h02; tick(); tick();
    n_total++;
    if (interrupt_out !== 1'b0) $display("FAIL rot_ir1_below_ir0: got %0b want 0", interrupt_out);
    else n_pass++;
    irr = 8'h04; tick();
    n_total++;
    if (interrupt_out !== 1'b1) $display("FAIL rot_ir2_highest: got %0b want 1", interrupt_out);
    else n_pass++;
    irr = 8'h00;
    eoi_specific = 1'b1; eoi_level = 3'd0; tick();
    eoi_specific = 1'b0; tick();
  endtask

  task automatic test_reset_in_gap();
    irr = 8'h10; tick();
    inta_n = 1'b0; tick();
    irr = 8'h00;
    n_total++;
    if (in_service_register !== 8'h10) $display("FAIL gap_isr_set: got %02h want 10", in_service_register);
    else n_pass++;
    inta_n = 1'b1; tick();
    reset = 1'b1; tick();
    n_total++;
    if ({interrupt_out, clear_interrupt_req, in_service_register, vector_out, vector_enable} !== 26'h0)
      $display("FAIL gap_reset: got int=%0b clr=%02h isr=%02h vec=%02h ven=%0b, want all 0",
               interrupt_out, clear_interrupt_req, in_service_register, vector_out, vector_enable);
    else n_pass++;
    reset = 1'b0; tick();
    n_total++;
    if (in_service_register !== 8'h00 || vector_enable !== 1'b0)
      $display("FAIL gap_after_release: got isr=%02h ven=%0b want 00/0", in_service_register, vector_enable);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; irr = 8'h00; mask = 8'h00; inta_n = 1'b1;
    aeoi_mode = 1'b0; rotate_on_eoi = 1'b0; eoi_nonspecific = 1'b0;
    eoi_specific = 1'b0; eoi_level = 3'd0; vector_base = 5'b10101;
    test_reset();
    test_basic_ack();
    test_nesting();
    test_spurious();
    test_aeoi();
    test_rotate();
    test_reset_in_gap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
